regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the RV32 core and its SoC variants, successor to the fixed 32x32 two-read-port file. It adds configurable width, depth and read-port count, a hardwired-zero register, and optional write-to-read bypass. It also has a sequential clear engine that zeroes storage one entry per cycle after reset, so no initial block is needed and the array can map to distributed RAM. It sits between decode (read addresses) and writeback (write port).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_rdport.sv | 41 ++++
 rtl/regfile_mp.sv | 129 ++++++++++++
 tb/tb_regfile_mp.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, defaults and helpers for the
// multi-port register file (regfile_mp and regfile_rdport).
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int RF_XLEN_DEF  = 32;
  localparam int RF_DEPTH_DEF = 32;

  // Address width for a given depth; never below 1 bit.
  function automatic int rf_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port (array mux, range and
// zero-reg checks, write bypass, force-to-zero while not ready).
// Ports: ready, mem (array), wr_hit_en/wr_addr/wr_data, rd_addr, rd_data.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN_DEF,
  parameter int DEPTH    = RF_DEPTH_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = rf_aw(DEPTH)
) (
  input  logic            ready,
  input  logic [XLEN-1:0] mem [DEPTH],
  input  logic            wr_hit_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_data
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic in_range;
  logic is_zero;
  logic byp_hit;

  assign in_range = {1'b0, rd_addr} < DEPTH_W;
  assign is_zero  = (ZERO_REG != 0) && (rd_addr == '0);
  // wr_hit_en is only high for a write that will really land
  assign byp_hit  = (BYPASS != 0) && wr_hit_en
                 && (wr_addr == rd_addr);

  always_comb begin
    rd_data = '0;
    if (ready && in_range && !is_zero) begin
      rd_data = byp_hit ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with a
// post-reset sequential clear engine and optional write bypass.
// Ports: clk, rst (sync, active-low), rf_ready, wr_en/wr_addr/wr_data,
// rd_addr (NRD*AW), rd_data (NRD*XLEN).
// Build option REGFILE_DBG_PORT_EN adds dbg_sel / dbg_data
// (registered, one-cycle latency, no bypass).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN_DEF,
  parameter int DEPTH    = RF_DEPTH_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = rf_aw(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                rf_ready,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data
`ifdef REGFILE_DBG_PORT_EN
  ,
  input  logic [AW-1:0]       dbg_sel,
  output logic [XLEN-1:0]     dbg_data
`endif
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rf_state_t       state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;
  logic            wr_ok;
  logic            wr_acc;

  assign wr_ok  = ({1'b0, wr_addr} < DEPTH_W)
               && !((ZERO_REG != 0) && (wr_addr == '0));
  // A write presented while rst is low is dropped
  assign wr_acc = rst && (state_q == RF_RUN)
               && wr_en && wr_ok;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_wa    = wr_addr;
    mem_wd    = wr_data;
    if (!rst) begin
      state_d   = RF_CLEAR;
      clr_idx_d = '0;
      ready_d   = 1'b0;
    end else if (state_q == RF_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_idx_q;
      mem_wd = '0;
      if (clr_idx_q == LAST_IDX) begin
        state_d   = RF_RUN;
        ready_d   = 1'b1;
        clr_idx_d = '0;
      end else begin
        clr_idx_d = clr_idx_q + 1'b1;
      end
    end else begin
      mem_we = wr_acc;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    ready_q   <= ready_d;
  end

  // No reset on the array so it can map to distributed RAM
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign rf_ready = ready_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rdport #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rdport (
      .ready     (ready_q),
      .mem       (mem_q),
      .wr_hit_en (wr_acc),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr   (rd_addr[k*AW +: AW]),
      .rd_data   (rd_data[k*XLEN +: XLEN])
    );
  end

`ifdef REGFILE_DBG_PORT_EN
  logic [XLEN-1:0] dbg_data_q, dbg_data_d;

  always_comb begin
    dbg_data_d = '0;
    if (rst && (state_q == RF_RUN)
        && ({1'b0, dbg_sel} < DEPTH_W)) begin
      dbg_data_d = mem_q[dbg_sel];
    end
  end

  always_ff @(posedge clk) begin
    dbg_data_q <= dbg_data_d;
  end

  assign dbg_data = dbg_data_q;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp, two instances
// (32-deep zero-reg+bypass, 24-deep no zero-reg, no bypass).
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en;
  logic [4:0]  wa, ra0, ra1;
  logic [31:0] wd;
  logic        rdy_a, rdy_b;
  logic [63:0] rd_a;
  logic [31:0] rd_b;
`ifdef REGFILE_DBG_PORT_EN
  logic [4:0]  dsel;
  logic [31:0] dbg_a, dbg_b;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
    int          due;
  } exp_t;

  exp_t sb[$];

  regfile_mp #(
    .DEPTH(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)
  ) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .rf_ready (rdy_a),
    .wr_en    (wr_en),
    .wr_addr  (wa),
    .wr_data  (wd),
    .rd_addr  ({ra1, ra0}),
    .rd_data  (rd_a)
`ifdef REGFILE_DBG_PORT_EN
    ,
    .dbg_sel  (dsel),
    .dbg_data (dbg_a)
`endif
  );

  regfile_mp #(
    .DEPTH(24), .NRD(1), .ZERO_REG(0), .BYPASS(0)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .rf_ready (rdy_b),
    .wr_en    (wr_en),
    .wr_addr  (wa),
    .wr_data  (wd),
    .rd_addr  (ra0),
    .rd_data  (rd_b)
`ifdef REGFILE_DBG_PORT_EN
    ,
    .dbg_sel  (dsel),
    .dbg_data (dbg_b)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pick(input int s);
    case (s)
      0: return rd_a[31:0];
      1: return rd_a[63:32];
      2: return {31'd0, rdy_a};
      3: return rd_b;
      4: return {31'd0, rdy_b};
`ifdef REGFILE_DBG_PORT_EN
      5: return dbg_a;
      6: return dbg_b;
`endif
      default: return 'x;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, pick(sb[i].sig), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic push(input string tag, input int sig,
                      input logic [31:0] v, input int lat);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = v;
    e.due = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic exp_rd(input string tag, input logic [31:0] a0,
                        input logic [31:0] a1,
                        input logic [31:0] b0);
    push({tag, "_a0"}, 0, a0, 0);
    push({tag, "_a1"}, 1, a1, 0);
    push({tag, "_b0"}, 3, b0, 0);
  endtask

  task automatic exp_rdy(input string tag, input logic a,
                         input logic b);
    push({tag, "_rdy_a"}, 2, {31'd0, a}, 0);
    push({tag, "_rdy_b"}, 4, {31'd0, b}, 0);
  endtask

  task automatic exp_dbg(input string tag, input logic [31:0] a,
                         input logic [31:0] b);
`ifdef REGFILE_DBG_PORT_EN
    push({tag, "_dbg_a"}, 5, a, 1);
    push({tag, "_dbg_b"}, 6, b, 1);
`else
    if (a === b) begin end
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wa    = a;
    wd    = d;
  endtask

  task automatic set_dsel(input logic [4:0] s);
`ifdef REGFILE_DBG_PORT_EN
    dsel = s;
`else
    if (s === 5'd0) begin end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0;
    wa = '0; wd = '0; ra0 = '0; ra1 = '0;
    set_dsel(5'd0);
    tick();
    exp_rdy("rst", 1'b0, 1'b0);
    tick();
    tick();

    // Clear timing: ready on edge 32 (A) and 24 (B)
    rst = 1'b1; ra0 = 5'd5; ra1 = 5'd23;
    exp_rdy("clr0", 1'b0, 1'b0);
    for (int n = 1; n <= 32; n++) begin
      tick();
      exp_rdy("clr", n == 32, n >= 24);
      exp_rd("clr", 32'd0, 32'd0, 32'd0);
    end

    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'(31 - i);
      exp_rd("scan", 32'd0, 32'd0, 32'd0);
      tick();
    end

    // Basic write / read on both ports
    wr(5'd5, 32'hDEADBEEF); ra0 = 5'd0; ra1 = 5'd0;
    exp_rd("w5_pre", 32'd0, 32'd0, 32'd0);
    tick();
    wr_en = 1'b0; ra0 = 5'd5; ra1 = 5'd5; set_dsel(5'd5);
    exp_rd("r5", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    exp_dbg("r5", 32'hDEADBEEF, 32'hDEADBEEF);
    tick();

    // Zero register
    wr(5'd0, 32'h12345678); ra0 = 5'd0; ra1 = 5'd5;
    exp_rd("w0_byp", 32'd0, 32'hDEADBEEF, 32'd0);
    tick();
    wr_en = 1'b0; set_dsel(5'd0);
    exp_rd("r0", 32'd0, 32'hDEADBEEF, 32'h12345678);
    exp_dbg("r0", 32'd0, 32'h12345678);
    tick();

    // Bypass vs no bypass
    wr(5'd7, 32'h1);
    tick();
    wr(5'd7, 32'h2); ra0 = 5'd7; ra1 = 5'd7;
    exp_rd("byp", 32'h2, 32'h2, 32'h1);
    tick();
    wr_en = 1'b0;
    exp_rd("byp_nx", 32'h2, 32'h2, 32'h2);
    tick();

    // Non-power-of-2 depth and out-of-range
    wr(5'd23, 32'h55);
    tick();
    wr(5'd30, 32'h99); ra0 = 5'd23; ra1 = 5'd30;
    set_dsel(5'd23);
    exp_rd("r23", 32'h55, 32'h99, 32'h55);
    exp_dbg("r23", 32'h55, 32'h55);
    tick();
    wr_en = 1'b0; ra0 = 5'd30; ra1 = 5'd23;
    set_dsel(5'd30);
    exp_rd("r30", 32'h99, 32'h55, 32'd0);
    exp_dbg("r30", 32'h99, 32'd0);
    tick();

    // Reset mid-run with a colliding write
    wr(5'd3, 32'hAA);
    tick();
    rst = 1'b0; wr(5'd4, 32'hBB); ra0 = 5'd3; ra1 = 5'd4;
    exp_rd("mrst", 32'hAA, 32'd0, 32'hAA);
    exp_rdy("mrst", 1'b1, 1'b1);
    tick();
    rst = 1'b1; wr(5'd9, 32'h77); ra0 = 5'd23; ra1 = 5'd5;
    set_dsel(5'd23);
    exp_rdy("mclr0", 1'b0, 1'b0);
    exp_rd("mclr0", 32'd0, 32'd0, 32'd0);
    exp_dbg("mclr0", 32'd0, 32'd0);
    for (int n = 1; n <= 32; n++) begin
      tick();
      if (n == 24) wr_en = 1'b0;
      exp_rdy("mclr", n == 32, n >= 24);
      exp_rd("mclr", 32'd0, 32'd0, 32'd0);
      exp_dbg("mclr", 32'd0, 32'd0);
    end
    tick();
    ra0 = 5'd9; ra1 = 5'd4;
    exp_rd("post9", 32'd0, 32'd0, 32'd0);
    tick();
    ra0 = 5'd3; ra1 = 5'd9;
    exp_rd("post3", 32'd0, 32'd0, 32'd0);
    tick();
    wr(5'd4, 32'hBB);
    tick();
    wr_en = 1'b0; ra0 = 5'd4; ra1 = 5'd4;
    exp_rd("post4", 32'hBB, 32'hBB, 32'hBB);
    tick();
    tick();

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
